lcd_cmd_sequencer: RTL and testbench

Sequencer that owns the character-LCD write bus and configures it. After reset it waits for panel power-up, then plays a fixed initialization command list with correct enable-pulse and settle timing. It then serves byte writes issued by the Nios II through the custom-instruction handshake (start/done), inserting per-command delays so software never busy-waits on the panel. It sits between the custom-instruction slot and the LCD pins, and replaces the free-running init logic.

---
 rtl/lcd_cmd_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_cmd_sequencer
// Function : Character-LCD write sequencer. Power-up wait, fixed init list,
//            then custom-instruction byte writes with enable/settle timing.
// Revision : 1.0
// ============================================================================
module lcd_cmd_sequencer #(
    parameter int unsigned POWERUP_CYC  = 2_000_000,
    parameter int unsigned EN_HIGH_CYC  = 25,
    parameter int unsigned CMD_WAIT_CYC = 2_000,
    parameter int unsigned CLR_WAIT_CYC = 82_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        done,
    output logic [31:0] result,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        init_done
);

    localparam int unsigned c_max_a   = (POWERUP_CYC > EN_HIGH_CYC) ? POWERUP_CYC : EN_HIGH_CYC;
    localparam int unsigned c_max_b   = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
    localparam int unsigned c_max_cyc = (c_max_a > c_max_b) ? c_max_a : c_max_b;
    localparam int          CNT_W     = $clog2(c_max_cyc + 1);

    localparam logic [CNT_W-1:0] c_pwr_last = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] c_en_last  = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] c_cmd_last = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] c_clr_last = CNT_W'(CLR_WAIT_CYC - 1);
    localparam logic [2:0]       c_init_last = 3'd7;

    typedef enum logic [2:0] {
        S_PWR_WAIT = 3'd0,
        S_SETUP    = 3'd1,
        S_PULSE    = 3'd2,
        S_SETTLE   = 3'd3,
        S_IDLE     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic             r_from_init;
    logic             r_pend_valid;
    logic [8:0]       r_pend_data;

    logic             w_is_clr;
    logic [CNT_W-1:0] w_settle_last;
    logic             w_unused;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        logic [7:0] cmd;
        case (idx)
            3'd0:    cmd = 8'h38;
            3'd1:    cmd = 8'h39;
            3'd2:    cmd = 8'h14;
            3'd3:    cmd = 8'h78;
            3'd4:    cmd = 8'h5E;
            3'd5:    cmd = 8'h6D;
            3'd6:    cmd = 8'h0C;
            default: cmd = 8'h01;
        endcase
        return cmd;
    endfunction

    // The bus holds the command being executed, so the settle length derives from it.
    assign w_is_clr      = ~lcd_rs & ((lcd_data == 8'h01) | (lcd_data == 8'h02));
    assign w_settle_last = w_is_clr ? c_clr_last : c_cmd_last;
    assign lcd_rw        = 1'b0;
    assign w_unused      = ^{dataa[31:9], datab};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_PWR_WAIT;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_from_init  <= 1'b1;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            lcd_data     <= '0;
            lcd_rs       <= 1'b0;
            lcd_en       <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            init_done    <= 1'b0;
        end else if (clk_en) begin
            done <= 1'b0;

            // Single-entry slot for requests arriving before the panel is ready.
            if (start && !init_done && !r_pend_valid) begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= dataa[8:0];
            end

            case (r_state)
                S_PWR_WAIT: begin
                    if (r_cnt == c_pwr_last) begin
                        r_cnt       <= '0;
                        r_idx       <= '0;
                        r_from_init <= 1'b1;
                        lcd_rs      <= 1'b0;
                        lcd_data    <= init_cmd(3'd0);
                        r_state     <= S_SETUP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_SETUP: begin
                    lcd_en  <= 1'b1;
                    r_state <= S_PULSE;
                end

                S_PULSE: begin
                    if (r_cnt == c_en_last) begin
                        r_cnt   <= '0;
                        lcd_en  <= 1'b0;
                        r_state <= S_SETTLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_SETTLE: begin
                    if (r_cnt == w_settle_last) begin
                        r_cnt <= '0;
                        if (!r_from_init) begin
                            done    <= 1'b1;
                            result  <= {23'd0, lcd_rs, lcd_data};
                            r_state <= S_DONE;
                        end else if (r_idx != c_init_last) begin
                            r_idx    <= r_idx + 3'd1;
                            lcd_rs   <= 1'b0;
                            lcd_data <= init_cmd(r_idx + 3'd1);
                            r_state  <= S_SETUP;
                        end else begin
                            init_done   <= 1'b1;
                            r_from_init <= 1'b0;
                            if (r_pend_valid) begin
                                r_pend_valid <= 1'b0;
                                lcd_rs       <= r_pend_data[8];
                                lcd_data     <= r_pend_data[7:0];
                                r_state      <= S_SETUP;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_IDLE: begin
                    // A request latched on the final init edge is served from here.
                    if (r_pend_valid) begin
                        r_pend_valid <= 1'b0;
                        lcd_rs       <= r_pend_data[8];
                        lcd_data     <= r_pend_data[7:0];
                        r_state      <= S_SETUP;
                    end else if (start) begin
                        lcd_rs   <= dataa[8];
                        lcd_data <= dataa[7:0];
                        r_state  <= S_SETUP;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_PWR_WAIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_cmd_sequencer
// Function : Directed self-checking bench for lcd_cmd_sequencer.
// Revision : 1.0
// ============================================================================
module tb_lcd_cmd_sequencer;

    localparam int unsigned POWERUP_CYC  = 100;
    localparam int unsigned EN_HIGH_CYC  = 3;
    localparam int unsigned CMD_WAIT_CYC = 10;
    localparam int unsigned CLR_WAIT_CYC = 40;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_en  = 1'b1;
    logic        start   = 1'b0;
    logic [31:0] dataa   = '0;
    logic [31:0] datab   = '0;
    logic        done;
    logic [31:0] result;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        init_done;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int np       = 0;
    int done_cnt = 0;
    int init_cyc = -1;
    int hold_bad = 0;
    logic [31:0] last_result = '0;

    int         rise_cyc  [32];
    int         width     [32];
    logic [7:0] rise_data [32];
    logic       rise_rs   [32];
    logic       pre_ok    [32];

    logic       prev_en, prev_rs, prev_done, prev_init;
    logic [7:0] prev_data;

    logic [7:0] init_list [8] = '{8'h38, 8'h39, 8'h14, 8'h78, 8'h5E, 8'h6D, 8'h0C, 8'h01};

    lcd_cmd_sequencer #(
        .POWERUP_CYC  (POWERUP_CYC),
        .EN_HIGH_CYC  (EN_HIGH_CYC),
        .CMD_WAIT_CYC (CMD_WAIT_CYC),
        .CLR_WAIT_CYC (CLR_WAIT_CYC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_en    (clk_en),
        .start     (start),
        .dataa     (dataa),
        .datab     (datab),
        .done      (done),
        .result    (result),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap_prev();
        prev_en   = lcd_en;
        prev_rs   = lcd_rs;
        prev_data = lcd_data;
        prev_done = done;
        prev_init = init_done;
    endtask

    task automatic sample();
        if (lcd_en && !prev_en && np < 32) begin
            rise_cyc[np]  = cyc;
            rise_data[np] = lcd_data;
            rise_rs[np]   = lcd_rs;
            pre_ok[np]    = (prev_data === lcd_data) && (prev_rs === lcd_rs);
        end
        if (lcd_en && prev_en && (lcd_data !== prev_data || lcd_rs !== prev_rs))
            hold_bad++;
        if (!lcd_en && prev_en) begin
            if (np < 32) width[np] = cyc - rise_cyc[np];
            np++;
        end
        if (done && !prev_done) begin
            done_cnt++;
            last_result = result;
        end
        if (init_done && !prev_init) init_cyc = cyc;
        snap_prev();
    endtask

    // Each step lands #1 after a rising edge; cyc names the window now visible.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        sample();
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        start   = 1'b0;
        clk_en  = 1'b1;
        #1;
        check({tag, "_en_async"}, {31'd0, lcd_en}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_data"},  {24'd0, lcd_data}, 32'd0);
        check({tag, "_rs"},    {31'd0, lcd_rs}, 32'd0);
        check({tag, "_rw"},    {31'd0, lcd_rw}, 32'd0);
        check({tag, "_en"},    {31'd0, lcd_en}, 32'd0);
        check({tag, "_done"},  {31'd0, done}, 32'd0);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_initd"}, {31'd0, init_done}, 32'd0);
        reset_n  = 1'b1;
        cyc      = 0;
        np       = 0;
        done_cnt = 0;
        init_cyc = -1;
        snap_prev();
    endtask

    task automatic check_init_pulses(input string tag);
        check({tag, "_init_cyc"}, init_cyc, 32'd242);
        for (int k = 0; k < 8; k++) begin
            check({tag, "_rise"},  rise_cyc[k], 101 + 14 * k);
            check({tag, "_cmd"},   {24'd0, rise_data[k]}, {24'd0, init_list[k]});
            check({tag, "_rs0"},   {31'd0, rise_rs[k]}, 32'd0);
            check({tag, "_width"}, width[k], EN_HIGH_CYC);
            check({tag, "_setup"}, {31'd0, pre_ok[k]}, 32'd1);
        end
    endtask

    task automatic do_req(input logic [8:0] d, input int exp_lat, input int frz_at,
                          input int frz_len, input int done_hold, input string tag);
        int t0, np0, dc0, n;
        t0    = cyc;
        np0   = np;
        dc0   = done_cnt;
        dataa = $urandom;
        dataa[8:0] = d;
        datab = $urandom;
        start = 1'b1;
        step();
        start = 1'b0;
        dataa = $urandom;
        n = 0;
        while (!done && n < 300) begin
            if (frz_len > 0 && cyc == t0 + frz_at) clk_en = 1'b0;
            if (frz_len > 0 && cyc == t0 + frz_at + frz_len) clk_en = 1'b1;
            step();
            n++;
        end
        check({tag, "_lat"},    cyc - t0, exp_lat);
        check({tag, "_result"}, result, {23'd0, d});
        check({tag, "_ndone"},  done_cnt, dc0 + 1);
        check({tag, "_npulse"}, np, np0 + 1);
        check({tag, "_data"},   {24'd0, rise_data[np0]}, {24'd0, d[7:0]});
        check({tag, "_rs"},     {31'd0, rise_rs[np0]}, {31'd0, d[8]});
        check({tag, "_width"},  width[np0], EN_HIGH_CYC + frz_len);
        check({tag, "_setup"},  {31'd0, pre_ok[np0]}, 32'd1);
        for (int h = 0; h < done_hold; h++) begin
            clk_en = 1'b0;
            step();
            check({tag, "_done_frozen"}, {31'd0, done}, 32'd1);
        end
        clk_en = 1'b1;
        step();
        check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int t0, np0, dc0, n;

        // Power-on reset and the full init list
        do_reset("por");
        check("por_cyc0_en", {31'd0, lcd_en}, 32'd0);
        while (cyc < 250) step();
        check("init1_npulse", np, 32'd8);
        check_init_pulses("init1");
        check("init1_nodone", done_cnt, 32'd0);

        // Back-to-back user writes: data, clear, home, plain command
        do_req(9'h141, 15, 0, 0, 0, "w141");
        do_req(9'h001, 45, 0, 0, 0, "clr");
        do_req(9'h002, 45, 0, 0, 0, "home");
        do_req(9'h080, 15, 0, 0, 0, "cmd80");

        // A start during an executing request is dropped
        t0  = cyc;
        np0 = np;
        dc0 = done_cnt;
        dataa = 32'h0000_0080;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        dataa = 32'h0000_0155;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            step();
            n++;
        end
        check("busy_lat", cyc - t0, 32'd15);
        check("busy_result", result, 32'h0000_0080);
        repeat (40) step();
        check("busy_ndone", done_cnt, dc0 + 1);
        check("busy_npulse", np, np0 + 1);

        // clk_en low for 7 cycles inside PULSE, then low across DONE
        do_req(9'h141, 22, 3, 7, 3, "frz");

        // Requests during init: first is queued, second dropped
        do_reset("rst2");
        while (cyc < 50) step();
        dataa = 32'hDEAD_0148;
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 60) step();
        dataa = 32'h0000_01AA;
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 320) step();
        check("pend_npulse", np, 32'd9);
        check_init_pulses("pend");
        check("pend_rise", rise_cyc[8], 32'd243);
        check("pend_data", {24'd0, rise_data[8]}, 32'h48);
        check("pend_rs", {31'd0, rise_rs[8]}, 32'd1);
        check("pend_ndone", done_cnt, 32'd1);
        check("pend_result", last_result, 32'h0000_0148);

        // Reset asserted in the middle of a user pulse
        dataa = 32'h0000_0141;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("mid_en_high", {31'd0, lcd_en}, 32'd1);
        do_reset("rst3");
        while (cyc < 250) step();
        check("rst3_npulse", np, 32'd8);
        check_init_pulses("rst3");
        check("rst3_nodone", done_cnt, 32'd0);

        check("hold_stable", hold_bad, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
